// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared encodings and instruction classification for the multicycle MIPS control unit
package mips_mc_pkg;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL  = 6'h03,
    OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07,
    OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
    OP_LB      = 6'h20, OP_LW     = 6'h23, OP_SW   = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_JR   = 6'h08,
    FN_JALR = 6'h09, FN_MFHI  = 6'h10, FN_MFLO = 6'h12, FN_MULT = 6'h18,
    FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU = 6'h1B, FN_ADD  = 6'h20,
    FN_ADDU = 6'h21, FN_SUB   = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24,
    FN_OR   = 6'h25, FN_XOR   = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;

  typedef enum logic [4:0] {RT_BLTZ = 5'h00, RT_BGEZ = 5'h01} regimm_t;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2,
    ST_MEM = 3'd3, ST_WB = 3'd4, ST_HALTED = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
    ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
    ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_ALU = 2'd1, PC_JUMP = 2'd2, PC_PENDING = 2'd3} pc_src_t;
  typedef enum logic [1:0] {M2R_ALU = 2'd0, M2R_MEM = 2'd1, M2R_PC8 = 2'd2, M2R_HILO = 2'd3} mem_to_reg_t;
  typedef enum logic [1:0] {RD_RT = 2'd0, RD_RD = 2'd1, RD_R31 = 2'd2} reg_dst_t;
  // SRCB_BRANCH is sign-extended immediate shifted left by two
  typedef enum logic [1:0] {SRCB_REG = 2'd0, SRCB_SEXT = 2'd1, SRCB_ZEXT = 2'd2, SRCB_BRANCH = 2'd3} alu_src_b_t;

  typedef enum logic [3:0] {
    CL_NOP, CL_ALU_R, CL_ALU_I, CL_HILO, CL_LOAD, CL_STORE,
    CL_BRANCH, CL_J, CL_JAL, CL_JR, CL_JALR, CL_MULDIV
  } cls_t;

  function automatic cls_t classify(input logic [31:0] ins);
    cls_t c;
    c = CL_NOP;
    case (ins[31:26])
      OP_SPECIAL: begin
        case (ins[5:0])
          FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: c = CL_ALU_R;
          FN_JR:                                          c = CL_JR;
          FN_JALR:                                        c = CL_JALR;
          FN_MFHI, FN_MFLO:                               c = CL_HILO;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:             c = CL_MULDIV;
          default:                                        c = CL_NOP;
        endcase
      end
      OP_REGIMM: if (ins[20:16] == RT_BLTZ || ins[20:16] == RT_BGEZ) c = CL_BRANCH;
      OP_J:                                   c = CL_J;
      OP_JAL:                                 c = CL_JAL;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:       c = CL_BRANCH;
      OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI:     c = CL_ALU_I;
      OP_LB, OP_LW:                           c = CL_LOAD;
      OP_SW:                                  c = CL_STORE;
      default:                                c = CL_NOP;
    endcase
    return c;
  endfunction

  function automatic alu_op_t alu_op_of(input logic [31:0] ins);
    alu_op_t a;
    a = ALU_ADD;
    case (ins[31:26])
      OP_SPECIAL: begin
        case (ins[5:0])
          FN_SLL:           a = ALU_SLL;
          FN_SRL:           a = ALU_SRL;
          FN_SRA:           a = ALU_SRA;
          FN_SUB, FN_SUBU:  a = ALU_SUB;
          FN_AND:           a = ALU_AND;
          FN_OR:            a = ALU_OR;
          FN_XOR:           a = ALU_XOR;
          FN_NOR:           a = ALU_NOR;
          FN_SLT:           a = ALU_SLT;
          FN_SLTU:          a = ALU_SLTU;
          default:          a = ALU_ADD;
        endcase
      end
      OP_SLTI:                                     a = ALU_SLT;
      OP_ANDI:                                     a = ALU_AND;
      OP_ORI:                                      a = ALU_OR;
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: a = ALU_SUB;
      default:                                     a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mc_muldiv_timer.sv
// rtl/mc_muldiv_timer.sv - down-counter that paces the multi-cycle multiply/divide EXEC stall
module mc_muldiv_timer #(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic idle,
  output logic done
);
  localparam int CW = $clog2(LAT + 1);

  logic [CW-1:0] count;

  // count holds the EXEC cycles still to go after the current one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= CW'(LAT - 1);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign idle = (count == '0);
  assign done = start ? (LAT == 1) : (count == CW'(1));

endmodule

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multicycle MIPS control FSM with wait-request, muldiv stall, delay slot and halt
module mips_mc_control
  import mips_mc_pkg::*;
#(
  parameter bit MEM_WAIT_EN   = 1'b1,
  parameter int MULDIV_LAT    = 4,
  parameter bit DELAY_SLOT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_waitrequest,
  input  logic        branch_cond,
  input  logic        pc_is_zero,
  output logic        active,
  output logic [2:0]  state,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        target_latch,
  output logic        muldiv_start,
  output logic        hilo_write
);

  state_t cur;
  logic   delay_pending;
  logic   in_slot;
  cls_t   cls;
  logic   mem_ready;
  logic   taken;
  logic   halt_now;
  logic   md_start;
  logic   md_idle;
  logic   md_done;
  logic   unused_instr_bits;

  assign cls               = classify(instr);
  assign mem_ready         = !MEM_WAIT_EN || !mem_waitrequest;
  assign halt_now          = (cur == ST_FETCH) && pc_is_zero && !delay_pending;
  assign md_start          = (cur == ST_EXEC) && (cls == CL_MULDIV) && md_idle;
  assign state             = cur;
  assign unused_instr_bits = ^{instr[25:21], instr[15:6]};

  always_comb begin
    taken = 1'b0;
    if (cls == CL_BRANCH) taken = branch_cond;
    else if (cls inside {CL_J, CL_JAL, CL_JR, CL_JALR}) taken = 1'b1;
  end

  mc_muldiv_timer #(.LAT(MULDIV_LAT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .idle  (md_idle),
    .done  (md_done)
  );

  // in_slot marks the instruction fetched by the pending redirect, so a transfer inside it is ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur           <= ST_FETCH;
      delay_pending <= 1'b0;
      in_slot       <= 1'b0;
    end else begin
      case (cur)
        ST_FETCH: begin
          if (halt_now) begin
            cur <= ST_HALTED;
          end else if (mem_ready) begin
            cur           <= ST_DECODE;
            in_slot       <= delay_pending;
            delay_pending <= 1'b0;
          end
        end
        ST_DECODE: cur <= ST_EXEC;
        ST_EXEC: begin
          if (taken && DELAY_SLOT_EN && !in_slot) delay_pending <= 1'b1;
          case (cls)
            CL_ALU_R, CL_ALU_I, CL_HILO, CL_JAL, CL_JALR: cur <= ST_WB;
            CL_LOAD, CL_STORE:                            cur <= ST_MEM;
            CL_MULDIV: if (md_done) cur <= ST_FETCH;
            default:                                      cur <= ST_FETCH;
          endcase
        end
        ST_MEM: if (mem_ready) cur <= (cls == CL_LOAD) ? ST_WB : ST_FETCH;
        ST_WB:     cur <= ST_FETCH;
        ST_HALTED: cur <= ST_HALTED;
        default:   cur <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    active       = (cur != ST_HALTED);
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_REG;
    alu_op       = ALU_ADD;
    reg_write    = 1'b0;
    reg_dst      = RD_RT;
    mem_to_reg   = M2R_ALU;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    target_latch = 1'b0;
    muldiv_start = 1'b0;
    hilo_write   = 1'b0;
    if (!reset) begin
      case (cur)
        ST_FETCH: begin
          if (!halt_now) begin
            mem_read = 1'b1;
            ir_write = mem_ready;
            pc_write = mem_ready;
            pc_src   = delay_pending ? PC_PENDING : PC_PLUS4;
          end
        end
        ST_DECODE: alu_src_b = SRCB_BRANCH;
        ST_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = alu_op_of(instr);
          case (cls)
            CL_ALU_I: alu_src_b = (instr[31:26] == OP_ANDI || instr[31:26] == OP_ORI) ? SRCB_ZEXT : SRCB_SEXT;
            CL_LOAD, CL_STORE: alu_src_b = SRCB_SEXT;
            CL_BRANCH: pc_src = PC_ALU;
            CL_J, CL_JAL, CL_JR, CL_JALR: pc_src = PC_JUMP;
            CL_MULDIV: begin
              muldiv_start = md_start;
              hilo_write   = md_done;
            end
            default: alu_src_b = SRCB_REG;
          endcase
          if (taken) begin
            if (DELAY_SLOT_EN) target_latch = !in_slot;
            else pc_write = 1'b1;
          end
        end
        ST_MEM: begin
          iord      = 1'b1;
          mem_read  = (cls == CL_LOAD);
          mem_write = (cls == CL_STORE);
        end
        ST_WB: begin
          reg_write = 1'b1;
          case (cls)
            CL_LOAD:  mem_to_reg = M2R_MEM;
            CL_JAL:   begin reg_dst = RD_R31; mem_to_reg = M2R_PC8; end
            CL_JALR:  begin reg_dst = RD_RD;  mem_to_reg = M2R_PC8; end
            CL_HILO:  begin reg_dst = RD_RD;  mem_to_reg = M2R_HILO; end
            CL_ALU_R: reg_dst = RD_RD;
            default:  reg_dst = RD_RT;
          endcase
        end
        default: active = (cur != ST_HALTED);
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// tb/tb_mips_mc_control.sv - directed self-checking bench for mips_mc_control
module tb_mips_mc_control;
  import mips_mc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        mem_waitrequest = 1'b0;
  logic        branch_cond = 1'b0;
  logic        pc_is_zero = 1'b0;
  logic        active, mem_read, mem_write, iord, ir_write, alu_src_a, reg_write;
  logic        pc_write, target_latch, muldiv_start, hilo_write;
  logic [2:0]  state;
  logic [1:0]  alu_src_b, reg_dst, mem_to_reg, pc_src;
  logic [3:0]  alu_op;
  logic [22:0] ctl;
  int          errors = 0;
  int          checks = 0;

  localparam logic [31:0] I_ADDU  = 32'h00221821;
  localparam logic [31:0] I_LW    = 32'h8C220004;
  localparam logic [31:0] I_SW    = 32'hAC220004;
  localparam logic [31:0] I_BEQ   = 32'h10220003;
  localparam logic [31:0] I_BNE   = 32'h14220002;
  localparam logic [31:0] I_ADDIU = 32'h24040005;
  localparam logic [31:0] I_MULT  = 32'h00220018;
  localparam logic [31:0] I_JAL   = 32'h0C000010;
  localparam logic [31:0] I_JR0   = 32'h00000008;
  localparam logic [31:0] I_NOP   = 32'h00000000;
  localparam logic [31:0] I_UNDEF = 32'hFC000000;

  always #5 clk = ~clk;

  assign ctl = {mem_read, mem_write, iord, ir_write, alu_src_a, alu_src_b, alu_op, reg_write,
                reg_dst, mem_to_reg, pc_write, pc_src, target_latch, muldiv_start, hilo_write};

  mips_mc_control #(.MEM_WAIT_EN(1'b1), .MULDIV_LAT(4), .DELAY_SLOT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_waitrequest(mem_waitrequest),
    .branch_cond(branch_cond), .pc_is_zero(pc_is_zero), .active(active), .state(state),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_write(pc_write), .pc_src(pc_src),
    .target_latch(target_latch), .muldiv_start(muldiv_start), .hilo_write(hilo_write)
  );

  task automatic test_reset;
    #1;
    checks++; if (state !== ST_FETCH) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, ST_FETCH); end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL reset_active: got %b expected 1", active); end
    checks++; if (ctl !== 23'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", ctl); end
    @(posedge clk); #2; reset = 1'b0;
  endtask

  task automatic test_addu;
    logic [2:0] es [4] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_WB};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); if (i == 0) instr = I_ADDU; #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL addu_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      checks++; if (reg_write !== (i == 3)) begin errors++; $display("FAIL addu_reg_write[%0d]: got %b expected %b", i, reg_write, i == 3); end
      if (i == 0) begin
        checks++; if ({mem_read, iord, ir_write, pc_write, pc_src} !== 6'b101100) begin errors++; $display("FAIL addu_fetch: got %b expected 101100", {mem_read, iord, ir_write, pc_write, pc_src}); end
      end
      if (i == 3) begin
        checks++; if (reg_dst !== 2'd1) begin errors++; $display("FAIL addu_reg_dst: got %0d expected 1", reg_dst); end
      end
    end
  endtask

  task automatic test_lw_wait;
    logic [2:0] es [8] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_MEM, ST_MEM, ST_MEM, ST_WB};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); if (i == 0) instr = I_LW; mem_waitrequest = (i >= 3 && i <= 5); #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      checks++; if (reg_write !== (i == 7)) begin errors++; $display("FAIL lw_reg_write[%0d]: got %b expected %b", i, reg_write, i == 7); end
      if (i >= 3 && i <= 6) begin
        checks++; if ({mem_read, iord, mem_write} !== 3'b110) begin errors++; $display("FAIL lw_mem_hold[%0d]: got %b expected 110", i, {mem_read, iord, mem_write}); end
      end
      if (i == 2) begin
        checks++; if ({alu_src_a, alu_src_b, alu_op} !== 7'b1010000) begin errors++; $display("FAIL lw_addr_calc: got %b expected 1010000", {alu_src_a, alu_src_b, alu_op}); end
      end
      if (i == 7) begin
        checks++; if ({reg_dst, mem_to_reg} !== 4'b0001) begin errors++; $display("FAIL lw_wb_sel: got %b expected 0001", {reg_dst, mem_to_reg}); end
      end
    end
    mem_waitrequest = 1'b0;
  endtask

  task automatic test_sw;
    logic [2:0] es [4] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); if (i == 0) instr = I_SW; #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL sw_reg_write[%0d]: got %b expected 0", i, reg_write); end
      if (i == 3) begin
        checks++; if ({mem_read, iord, mem_write} !== 3'b011) begin errors++; $display("FAIL sw_mem: got %b expected 011", {mem_read, iord, mem_write}); end
      end
    end
  endtask

  task automatic test_beq_not_taken;
    logic [2:0] es [3] = '{ST_FETCH, ST_DECODE, ST_EXEC};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); if (i == 0) instr = I_BEQ; branch_cond = 1'b0; #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL bnt_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      if (i == 2) begin
        checks++; if ({target_latch, pc_write} !== 2'b00) begin errors++; $display("FAIL bnt_no_redirect: got %b expected 00", {target_latch, pc_write}); end
      end
    end
  endtask

  task automatic test_beq_slot;
    logic [2:0] es [7] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) instr = I_BEQ;
      if (i == 3) instr = I_ADDIU;
      branch_cond = (i == 2);
      #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL slot_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      checks++; if (target_latch !== (i == 2)) begin errors++; $display("FAIL slot_target_latch[%0d]: got %b expected %b", i, target_latch, i == 2); end
      checks++; if (pc_write !== (i == 0 || i == 3)) begin errors++; $display("FAIL slot_pc_write[%0d]: got %b expected %b", i, pc_write, i == 0 || i == 3); end
      if (i == 0 || i == 3) begin
        checks++; if (pc_src !== ((i == 3) ? 2'd3 : 2'd0)) begin errors++; $display("FAIL slot_fetch_pc_src[%0d]: got %0d expected %0d", i, pc_src, (i == 3) ? 3 : 0); end
      end
      if (i == 6) begin
        checks++; if ({reg_write, reg_dst} !== 3'b100) begin errors++; $display("FAIL slot_addiu_wb: got %b expected 100", {reg_write, reg_dst}); end
      end
    end
    branch_cond = 1'b0;
  endtask

  task automatic test_branch_in_slot;
    logic [2:0] es [6] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_FETCH, ST_DECODE, ST_EXEC};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) instr = I_BEQ;
      if (i == 3) instr = I_BNE;
      branch_cond = (i == 2 || i == 5);
      #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL bis_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      checks++; if (target_latch !== (i == 2)) begin errors++; $display("FAIL bis_target_latch[%0d]: got %b expected %b", i, target_latch, i == 2); end
      if (i == 0 || i == 3) begin
        checks++; if (pc_src !== ((i == 3) ? 2'd3 : 2'd0)) begin errors++; $display("FAIL bis_fetch_pc_src[%0d]: got %0d expected %0d", i, pc_src, (i == 3) ? 3 : 0); end
      end
    end
    branch_cond = 1'b0;
  endtask

  task automatic test_mult;
    logic [2:0] es [6] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_EXEC, ST_EXEC, ST_EXEC};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); if (i == 0) instr = I_MULT; #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL mult_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      checks++; if (muldiv_start !== (i == 2)) begin errors++; $display("FAIL mult_start[%0d]: got %b expected %b", i, muldiv_start, i == 2); end
      checks++; if (hilo_write !== (i == 5)) begin errors++; $display("FAIL mult_hilo_write[%0d]: got %b expected %b", i, hilo_write, i == 5); end
      if (i == 0) begin
        checks++; if (pc_src !== 2'd0) begin errors++; $display("FAIL mult_fetch_pc_src: got %0d expected 0", pc_src); end
      end
    end
  endtask

  task automatic test_jal;
    logic [2:0] es [8] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) instr = I_JAL;
      if (i == 4) instr = I_NOP;
      #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL jal_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      checks++; if (reg_write !== (i == 3 || i == 7)) begin errors++; $display("FAIL jal_reg_write[%0d]: got %b expected %b", i, reg_write, i == 3 || i == 7); end
      if (i == 2) begin
        checks++; if ({target_latch, pc_write, pc_src} !== 4'b1010) begin errors++; $display("FAIL jal_exec: got %b expected 1010", {target_latch, pc_write, pc_src}); end
      end
      if (i == 3) begin
        checks++; if ({reg_dst, mem_to_reg} !== 4'b1010) begin errors++; $display("FAIL jal_link: got %b expected 1010", {reg_dst, mem_to_reg}); end
      end
      if (i == 4) begin
        checks++; if (pc_src !== 2'd3) begin errors++; $display("FAIL jal_slot_pc_src: got %0d expected 3", pc_src); end
      end
    end
  endtask

  task automatic test_undef;
    logic [2:0] es [3] = '{ST_FETCH, ST_DECODE, ST_EXEC};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); if (i == 0) instr = I_UNDEF; #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL undef_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      if (i == 2) begin
        checks++;
        if ({mem_read, mem_write, ir_write, reg_write, pc_write, target_latch, muldiv_start, hilo_write} !== 8'd0) begin
          errors++; $display("FAIL undef_writes: got %b expected 0", {mem_read, mem_write, ir_write, reg_write, pc_write, target_latch, muldiv_start, hilo_write});
        end
      end
    end
  endtask

  task automatic test_halt;
    logic [2:0] es [10] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_FETCH, ST_HALTED, ST_HALTED};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) instr = I_JR0;
      if (i == 3) instr = I_NOP;
      pc_is_zero = (i >= 7);
      #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL halt_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      checks++; if (active !== (i < 8)) begin errors++; $display("FAIL halt_active[%0d]: got %b expected %b", i, active, i < 8); end
      if (i == 2) begin
        checks++; if ({target_latch, pc_src} !== 3'b110) begin errors++; $display("FAIL halt_jr_latch: got %b expected 110", {target_latch, pc_src}); end
      end
      if (i == 3) begin
        checks++; if ({mem_read, pc_src} !== 3'b111) begin errors++; $display("FAIL halt_slot_fetch: got %b expected 111", {mem_read, pc_src}); end
      end
      if (i == 7) begin
        checks++; if ({mem_read, ir_write, pc_write} !== 3'b000) begin errors++; $display("FAIL halt_no_access: got %b expected 000", {mem_read, ir_write, pc_write}); end
      end
      if (i >= 8) begin
        checks++; if (ctl !== 23'd0) begin errors++; $display("FAIL halted_outputs[%0d]: got %h expected 0", i, ctl); end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [2:0] es [4] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM};
    @(negedge clk); #1;
    checks++; if (state !== ST_HALTED) begin errors++; $display("FAIL rst_still_halted: got %0d expected %0d", state, ST_HALTED); end
    reset = 1'b1; #1;
    checks++; if ({state, active} !== 4'b0001) begin errors++; $display("FAIL rst_from_halt: got %b expected 0001", {state, active}); end
    pc_is_zero = 1'b0;
    @(posedge clk); #2; reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); if (i == 0) instr = I_LW; mem_waitrequest = (i == 3); #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL rst_lw_state[%0d]: got %0d expected %0d", i, state, es[i]); end
    end
    #2; reset = 1'b1; #1;
    checks++; if (ctl !== 23'd0) begin errors++; $display("FAIL rst_mid_wait_outputs: got %h expected 0", ctl); end
    checks++; if ({state, active} !== 4'b0001) begin errors++; $display("FAIL rst_mid_wait_state: got %b expected 0001", {state, active}); end
    @(posedge clk); #2; reset = 1'b0; mem_waitrequest = 1'b0;
    @(negedge clk); instr = I_BEQ; #1;
    checks++; if ({state, active, mem_read, pc_src} !== 7'b0001100) begin errors++; $display("FAIL rst_release_fetch: got %b expected 0001100", {state, active, mem_read, pc_src}); end
    @(negedge clk);
    @(negedge clk); branch_cond = 1'b1; #1;
    checks++; if (target_latch !== 1'b1) begin errors++; $display("FAIL rst_beq_latch: got %b expected 1", target_latch); end
    @(negedge clk); branch_cond = 1'b0; #1;
    checks++; if (pc_src !== 2'd3) begin errors++; $display("FAIL rst_pending_before: got %0d expected 3", pc_src); end
    #2; reset = 1'b1;
    @(posedge clk); #2; reset = 1'b0;
    @(negedge clk); #1;
    checks++; if ({state, pc_src} !== 5'b00000) begin errors++; $display("FAIL rst_pending_cleared: got %b expected 00000", {state, pc_src}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_sw();
    test_beq_not_taken();
    test_beq_slot();
    test_branch_in_slot();
    test_mult();
    test_jal();
    test_undef();
    test_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multicycle MIPS control unit: the next-generation instruction decoder/state machine driving the shared-bus multicycle datapath (PC, IR, register file, ALU, HI/LO, memory port). Over the current decoder it adds a memory wait-request handshake, a configurable multi-cycle multiply/divide stall, architectural branch-delay-slot sequencing, and a halt-on-jump-to-zero mode. One instance sits beside the datapath; every datapath mux select and write enable comes from this block.

## Interface
- MEM_WAIT_EN, 1: 1 = honour `mem_waitrequest`; 0 = input ignored, memory is single-cycle.
- MULDIV_LAT, 4: EXEC cycles for MULT/MULTU/DIV/DIVU, range 1..32.
- DELAY_SLOT_EN, 1: 1 = MIPS delay slot; 0 = taken branch/jump redirects immediately.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- instr  in  32  IR contents, valid from DECODE onward.
- mem_waitrequest  in  1  memory not ready; hold current access.
- branch_cond  in  1  datapath condition result for the current branch (EXEC cycle).
- pc_is_zero  in  1  PC == 0, sampled in FETCH.
- active  out  1  high unless HALTED.
- state  out  3  current state_t, for debug.
- mem_read, mem_write, iord, ir_write  out  1 each  memory/IR controls.
- alu_src_a  out  1; alu_src_b  out  2; alu_op  out  4 (alu_op_t).
- reg_write  out  1; reg_dst  out  2 (rt / rd / r31); mem_to_reg  out  2 (ALU / mem / PC+8 / HI-LO).
- pc_write  out  1; pc_src  out  2 (PC+4 / ALU / jump target / pending target).
- target_latch  out  1  capture branch/jump target into datapath pending register.
- muldiv_start, hilo_write  out  1 each.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALTED.
- FETCH: mem_read=1, iord=0, ir_write=1; held while waitrequest (ir_write, pc_write only in completing cycle); completing cycle pc_write=1 with pc_src = PENDING if slot_done else PC+4. If pc_is_zero and no delay pending -> HALTED, no memory access.
- DECODE: register read, ALU computes PC+4+(imm<<2); always -> EXEC.
- EXEC per opcode: R-type ALU, immediates (ADDIU, ANDI, ORI, SLTI zero/sign-ext per op) -> WB; LW/LB/SW -> MEM with address computed; branches (BEQ, BNE, BGTZ, BLEZ, BLTZ, BGEZ) and J/JAL/JR/JALR -> FETCH (JAL/JALR via WB for link write, mem_to_reg=PC+8); MULT/DIV family held MULDIV_LAT cycles.
- MEM: iord=1, mem_read (loads) or mem_write (SW), held while waitrequest; loads -> WB, SW -> FETCH.
- WB: reg_write=1 exactly one cycle.
- Delay slot (DELAY_SLOT_EN=1): taken control transfer asserts target_latch, sets `delay_pending`; the next instruction (slot) executes normally; at its FETCH-complete the redirect uses pc_src=PENDING and clears the flag. Branch in delay slot: undefined architecturally; block must keep the first target and ignore the second latch.
- DELAY_SLOT_EN=0: taken transfer asserts pc_write, pc_src=ALU/jump in EXEC.
- Undefined opcode/funct: treated as NOP, EXEC -> FETCH, no writes.
- HALTED: absorbing until reset; all outputs 0.

## Timing
- Reset: state=FETCH, delay_pending=0, muldiv counter=0, active=1; all other outputs 0 while reset high.
- Zero-wait cycle counts: ALU/imm 4, LW/LB 5, SW 4, branch/J/JR 3, JAL/JALR 4, MULT/DIV 2+MULDIV_LAT.
- Each waitrequest cycle adds exactly one cycle; controls stable throughout the hold.
- muldiv_start on first EXEC cycle only; hilo_write on cycle MULDIV_LAT (MULDIV_LAT=1: both same cycle).
- No output ever writes twice per instruction; reg_write/mem_write never coincide.
- Reset mid-instruction (incl. mid-wait, mid-muldiv) aborts immediately; delay_pending cleared.

## Structure
- Package `mips_mc_pkg`: opcode_t, funct_t, regimm rt codes, state_t, alu_op_t, pc_src_t, mem_to_reg_t.
- Sub-module `mc_muldiv_timer`: $clog2(MULDIV_LAT+1)-bit down-counter, start/done; main FSM and decode in top.

## Test plan
- ADDU $3,$1,$2, no waits -> FETCH,DECODE,EXEC,WB; reg_write=1 in cycle 4 only, reg_dst=rd.
- LW with mem_waitrequest high 3 cycles in MEM -> total 8 cycles; mem_read/iord constant during hold; single reg_write.
- Taken BEQ, DELAY_SLOT_EN=1 -> target_latch in EXEC; slot ADDIU completes; its FETCH-complete uses pc_src=PENDING; delay_pending=0 after.
- MULT, MULDIV_LAT=4 -> muldiv_start EXEC cycle 1, hilo_write EXEC cycle 4, 6 cycles total.
- JR $0 then slot NOP -> next FETCH with pc_is_zero=1 -> HALTED, active=0, no mem_read.
- Reset asserted mid-MEM wait -> outputs 0 asynchronously; after release FETCH, active=1.
